alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Sequences packed command batches into the tinyalu datapath.
- Accepts one wide packet of CMD_NUM 24-bit command slots, issues each command to the ALU with the start/done handshake, and returns each result over a valid/ready stream.
- Sits between the DPI packet source and the tinyalu instance inside the bench BFM.
- Replaces ad-hoc per-clock slicing with a handshake-correct scheduler.

Parameters:
- CMD_NUM, 256, command slots per packet.
- CMD_W, 24, bits per slot: [7:0]=A, [15:8]=B, [18:16]=op, [23:19] ignored.
- PKT_W, CMD_NUM*CMD_W (6144), packet width.
- TIMEOUT, 15, maximum cycles in WAIT before abort.

Ports:
- clk_i  in  1  clock, all logic on posedge.
- reset_i  in  1  synchronous reset, active-high.
- pkt_valid_i  in  1  packet offered.
- pkt_ready_o  out  1  high only in IDLE.
- pkt_data_i  in  PKT_W  packet; slot 0 in the LSBs.
- alu_a_o  out  8  ALU operand A.
- alu_b_o  out  8  ALU operand B.
- alu_op_o  out  3  ALU opcode.
- alu_start_o  out  1  ALU start; held until done.
- alu_done_i  in  1  ALU done.
- alu_result_i  in  16  ALU result.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  consumer accepts.
- res_data_o  out  16  result value.
- res_idx_o  out  $clog2(CMD_NUM)  slot index of the result.
- res_err_o  out  1  result aborted by timeout.
- busy_o  out  1  high whenever not in IDLE.
- batch_done_o  out  1  one-cycle pulse after the last slot retires.

Behaviour:
- Reset: all outputs 0, except pkt_ready_o=1 (state IDLE). Packet register, slot index and timer are cleared.
- Reset mid-batch abandons the batch. alu_start_o is low the cycle after reset is sampled. No result is emitted.
- Valid opcodes: 1 add, 2 and, 3 xor, 4 mul. Opcodes 0, 5, 6 and 7 are skipped: no ALU start, no result emitted, slot index still advances.
- IDLE: on pkt_valid_i & pkt_ready_o, latch pkt_data_i, set idx=0, go to ISSUE.
- ISSUE (1 cycle): decode the low CMD_W bits of the shift register.
  - Skip opcode: go to NEXT.
  - Valid opcode: drive A/B/op, assert alu_start_o, clear timer, go to WAIT.
- WAIT: start, A, B and op are held stable.
  - On alu_done_i=1: register alu_result_i into res_data_o, res_err_o=0. alu_start_o drops in the following cycle. Go to RESP.
  - When the timer reaches TIMEOUT with no done: res_data_o=16'h0000, res_err_o=1, alu_start_o drops, go to RESP.
- RESP: res_valid_o=1, with res_data_o, res_idx_o and res_err_o stable until res_ready_i. The handshake completes in the cycle valid & ready; go to NEXT. alu_start_o is low in RESP, which guarantees at least one start-low cycle between ALU ops.
- NEXT (1 cycle): shift the packet register right by CMD_W.
  - If idx==CMD_NUM-1: pulse batch_done_o, go to IDLE.
  - Otherwise: idx++, go to ISSUE.
- Latency for an add with immediate done and ready: start at cycle t (ISSUE), done sampled at t+1, res_valid at t+2, next ISSUE at t+4.
- alu_done_i outside WAIT is ignored.
- res_idx_o wraps only via a new batch; it never exceeds CMD_NUM-1.
- pkt_valid_i while busy_o=1 is not accepted, and the offered packet is not consumed.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- Defined: adds outputs stat_issued_o[31:0], stat_skipped_o[31:0], stat_timeout_o[15:0] and stat_busy_cyc_o[31:0].
  - stat_issued_o: incremented per ISSUE with a valid opcode.
  - stat_skipped_o: incremented per skipped slot.
  - stat_timeout_o: incremented per timeout abort.
  - stat_busy_cyc_o: incremented every cycle busy_o=1.
  - All counters saturate, and reset to 0 only on reset_i.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Single add: slot0={op=1,B=8'h05,A=8'h03}, all other slots op=0, ALU done one cycle after start, res_ready_i=1 -> exactly one result: res_data_o=16'h0008, res_idx_o=0, res_err_o=0; batch_done_o pulses once; pkt_ready_o returns to 1.
- Mul hold: slot3={op=4,A=8'hFF,B=8'hFF}, done 3 cycles after start -> alu_start_o stays high for all WAIT cycles with A/B/op unchanged; result 16'hFE01 with res_idx_o=3.
- Backpressure: 2 valid adds, res_ready_i low for 5 cycles on the first result -> res_valid_o and data held for 5 cycles; second ISSUE occurs only after the handshake; no result lost or duplicated.
- Skip opcodes: slots 0..3 with op=0,5,6,7 and slot4 op=2, A=8'hF0, B=8'h3C -> alu_start_o never asserted for slots 0..3; the only result is 16'h0030 with res_idx_o=4.
- Timeout: ALU never asserts done for slot0 add -> after TIMEOUT (15) WAIT cycles, start drops and a result is emitted with res_err_o=1, res_data_o=0; the sequencer continues with slot1.
- Reset mid-batch: reset_i pulsed during WAIT of slot 10 -> next cycle all outputs are at reset values, no batch_done_o, and a new packet is accepted starting from idx 0.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Interface bundling the packet, ALU and result-stream signals of the
// ALU command sequencer. Optional statistics outputs appear only when
// ALU_SEQ_STATS_EN is defined.
interface alu_cmd_sequencer_if #(
   parameter int CMD_NUM = 256,
   parameter int CMD_W   = 24
);
   localparam int PKT_W = CMD_NUM * CMD_W;
   localparam int IDX_W = $clog2(CMD_NUM);

   logic             pkt_valid_i;
   logic             pkt_ready_o;
   logic [PKT_W-1:0] pkt_data_i;
   logic [7:0]       alu_a_o;
   logic [7:0]       alu_b_o;
   logic [2:0]       alu_op_o;
   logic             alu_start_o;
   logic             alu_done_i;
   logic [15:0]      alu_result_i;
   logic             res_valid_o;
   logic             res_ready_i;
   logic [15:0]      res_data_o;
   logic [IDX_W-1:0] res_idx_o;
   logic             res_err_o;
   logic             busy_o;
   logic             batch_done_o;
`ifdef ALU_SEQ_STATS_EN
   logic [31:0]      stat_issued_o;
   logic [31:0]      stat_skipped_o;
   logic [15:0]      stat_timeout_o;
   logic [31:0]      stat_busy_cyc_o;
`endif

   // Sequencer side
   modport master (
      input  pkt_valid_i, pkt_data_i, alu_done_i, alu_result_i, res_ready_i,
      output pkt_ready_o, alu_a_o, alu_b_o, alu_op_o, alu_start_o,
             res_valid_o, res_data_o, res_idx_o, res_err_o, busy_o, batch_done_o
`ifdef ALU_SEQ_STATS_EN
      , output stat_issued_o, stat_skipped_o, stat_timeout_o, stat_busy_cyc_o
`endif
   );

   // Packet source / ALU / result consumer side
   modport slave (
      output pkt_valid_i, pkt_data_i, alu_done_i, alu_result_i, res_ready_i,
      input  pkt_ready_o, alu_a_o, alu_b_o, alu_op_o, alu_start_o,
             res_valid_o, res_data_o, res_idx_o, res_err_o, busy_o, batch_done_o
`ifdef ALU_SEQ_STATS_EN
      , input stat_issued_o, stat_skipped_o, stat_timeout_o, stat_busy_cyc_o
`endif
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: takes one packet of CMD_NUM command slots,
// issues each valid command to the ALU with a start/done handshake and
// returns each result on a valid/ready stream. Define ALU_SEQ_STATS_EN to
// add saturating activity counters.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a packet, pkt_ready_o high
// ISSUE  | decode slot in the low bits of the shift register
// WAIT   | start held, waiting for done or timer terminal count
// RESP   | result offered, waiting for res_ready_i
// NEXT   | shift to next slot, or finish batch
module alu_cmd_sequencer #(
   parameter int CMD_NUM = 256,
   parameter int CMD_W   = 24,
   parameter int PKT_W   = CMD_NUM * CMD_W,
   parameter int TIMEOUT = 15
) (
   input logic                 clk_i,
   input logic                 reset_i,
   alu_cmd_sequencer_if.master bus
);
   localparam int IDX_W = $clog2(CMD_NUM);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_NEXT
   } state_t;

   state_t           state;
   logic [PKT_W-1:0] pkt_q;
   logic [IDX_W-1:0] idx;
   logic [TMR_W-1:0] timer;
   logic             op_valid;
   logic             last_slot;

   assign op_valid  = (pkt_q[18:16] >= 3'd1) && (pkt_q[18:16] <= 3'd4);
   assign last_slot = (idx == IDX_W'(CMD_NUM - 1));

   // Main sequencing FSM; all outputs registered
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state            <= S_IDLE;
         pkt_q            <= '0;
         idx              <= '0;
         timer            <= '0;
         bus.pkt_ready_o  <= 1'b1;
         bus.alu_a_o      <= '0;
         bus.alu_b_o      <= '0;
         bus.alu_op_o     <= '0;
         bus.alu_start_o  <= 1'b0;
         bus.res_valid_o  <= 1'b0;
         bus.res_data_o   <= '0;
         bus.res_idx_o    <= '0;
         bus.res_err_o    <= 1'b0;
         bus.busy_o       <= 1'b0;
         bus.batch_done_o <= 1'b0;
      end else begin
         bus.batch_done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.pkt_valid_i && bus.pkt_ready_o) begin
                  pkt_q           <= bus.pkt_data_i;
                  idx             <= '0;
                  bus.pkt_ready_o <= 1'b0;
                  bus.busy_o      <= 1'b1;
                  state           <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (op_valid) begin
                  bus.alu_a_o     <= pkt_q[7:0];
                  bus.alu_b_o     <= pkt_q[15:8];
                  bus.alu_op_o    <= pkt_q[18:16];
                  bus.alu_start_o <= 1'b1;
                  // down-counter; terminal count at zero gives TIMEOUT wait cycles
                  timer           <= TMR_W'(TIMEOUT - 1);
                  state           <= S_WAIT;
               end else begin
                  state <= S_NEXT;
               end
            end
            S_WAIT: begin
               if (bus.alu_done_i) begin
                  bus.res_data_o  <= bus.alu_result_i;
                  bus.res_err_o   <= 1'b0;
                  bus.res_idx_o   <= idx;
                  bus.res_valid_o <= 1'b1;
                  bus.alu_start_o <= 1'b0;
                  state           <= S_RESP;
               end else if (timer == '0) begin
                  bus.res_data_o  <= 16'h0000;
                  bus.res_err_o   <= 1'b1;
                  bus.res_idx_o   <= idx;
                  bus.res_valid_o <= 1'b1;
                  bus.alu_start_o <= 1'b0;
                  state           <= S_RESP;
               end else begin
                  timer <= timer - TMR_W'(1);
               end
            end
            S_RESP: begin
               if (bus.res_ready_i) begin
                  bus.res_valid_o <= 1'b0;
                  state           <= S_NEXT;
               end
            end
            S_NEXT: begin
               pkt_q <= pkt_q >> CMD_W;
               if (last_slot) begin
                  bus.batch_done_o <= 1'b1;
                  bus.pkt_ready_o  <= 1'b1;
                  bus.busy_o       <= 1'b0;
                  state            <= S_IDLE;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  state <= S_ISSUE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_STATS_EN
   // Saturating activity counters, cleared only by reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         bus.stat_issued_o   <= '0;
         bus.stat_skipped_o  <= '0;
         bus.stat_timeout_o  <= '0;
         bus.stat_busy_cyc_o <= '0;
      end else begin
         if (state == S_ISSUE && op_valid && bus.stat_issued_o != '1)
            bus.stat_issued_o <= bus.stat_issued_o + 32'd1;
         if (state == S_ISSUE && !op_valid && bus.stat_skipped_o != '1)
            bus.stat_skipped_o <= bus.stat_skipped_o + 32'd1;
         if (state == S_WAIT && !bus.alu_done_i && timer == '0 &&
             bus.stat_timeout_o != '1)
            bus.stat_timeout_o <= bus.stat_timeout_o + 16'd1;
         if (bus.busy_o && bus.stat_busy_cyc_o != '1)
            bus.stat_busy_cyc_o <= bus.stat_busy_cyc_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU responder
// and a result/start/batch-done monitor.
module tb_alu_cmd_sequencer;
   localparam int CMD_NUM = 256;
   localparam int CMD_W   = 24;
   localparam int PKT_W   = CMD_NUM * CMD_W;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   alu_cmd_sequencer_if #(.CMD_NUM(CMD_NUM), .CMD_W(CMD_W)) sif ();

   alu_cmd_sequencer #(.CMD_NUM(CMD_NUM), .CMD_W(CMD_W), .PKT_W(PKT_W), .TIMEOUT(15)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (sif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ALU responder: done after done_dly cycles of start high (0 = never)
   int done_dly = 1;
   int wcnt     = 0;

   function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
      case (op)
         3'd1:    return {8'h00, a} + {8'h00, b};
         3'd2:    return {8'h00, a & b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return {8'h00, a} * {8'h00, b};
         default: return 16'h0000;
      endcase
   endfunction

   initial begin
      sif.alu_done_i   = 1'b0;
      sif.alu_result_i = 16'h0000;
      forever begin
         @(negedge clk);
         if (sif.alu_start_o) begin
            wcnt++;
            if (done_dly != 0 && wcnt == done_dly) begin
               sif.alu_done_i   = 1'b1;
               sif.alu_result_i = alu_ref(sif.alu_a_o, sif.alu_b_o, sif.alu_op_o);
            end else begin
               sif.alu_done_i = 1'b0;
            end
         end else begin
            wcnt           = 0;
            sif.alu_done_i = 1'b0;
         end
      end
   end

   // Monitor: records accepted results, start rises and batch_done pulses
   logic [15:0] rq_data[$];
   int          rq_idx[$];
   logic        rq_err[$];
   int          nstart  = 0;
   int          nbdone  = 0;
   logic [7:0]  first_a = 8'h00;
   logic        prev_start = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (sif.res_valid_o && sif.res_ready_i) begin
            rq_data.push_back(sif.res_data_o);
            rq_idx.push_back(int'(sif.res_idx_o));
            rq_err.push_back(sif.res_err_o);
         end
         if (sif.alu_start_o && !prev_start) begin
            if (nstart == 0) first_a = sif.alu_a_o;
            nstart++;
         end
         if (sif.batch_done_o) nbdone++;
         prev_start = sif.alu_start_o;
      end
   end

   logic [PKT_W-1:0] pkt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      rq_data.delete();
      rq_idx.delete();
      rq_err.delete();
      nstart  = 0;
      nbdone  = 0;
      first_a = 8'h00;
   endtask

   task automatic set_slot(input int s, input logic [2:0] op, input logic [7:0] b,
                           input logic [7:0] a);
      pkt[s*CMD_W +: CMD_W] = {5'b00000, op, b, a};
   endtask

   function automatic logic [15:0] get_d(input int i);
      return (i < rq_data.size()) ? rq_data[i] : 16'hDEAD;
   endfunction
   function automatic int get_i(input int i);
      return (i < rq_idx.size()) ? rq_idx[i] : -1;
   endfunction
   function automatic logic get_e(input int i);
      return (i < rq_err.size()) ? rq_err[i] : 1'bx;
   endfunction

   task automatic send_pkt(input string tag);
      int n = 0;
      while (!sif.pkt_ready_o && n < 100) begin
         step();
         n++;
      end
      sif.pkt_data_i  = pkt;
      sif.pkt_valid_i = 1'b1;
      step();
      sif.pkt_valid_i = 1'b0;
      chk({tag, "_accept_busy"}, sif.busy_o, 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (sif.busy_o && n < 3000) begin
         step();
         n++;
      end
      chk({tag, "_idle"}, sif.busy_o, 0);
      step();
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (!sif.alu_start_o && n < 200) begin
         step();
         n++;
      end
      chk({tag, "_start_seen"}, sif.alu_start_o, 1);
   endtask

   initial begin
      int hold;
      int scnt;

      reset           = 1'b1;
      sif.pkt_valid_i = 1'b0;
      sif.pkt_data_i  = '0;
      sif.res_ready_i = 1'b0;
      pkt             = '0;
      repeat (3) step();

      // reset values
      chk("rst_pkt_ready", sif.pkt_ready_o, 1);
      chk("rst_busy", sif.busy_o, 0);
      chk("rst_start", sif.alu_start_o, 0);
      chk("rst_res_valid", sif.res_valid_o, 0);
      chk("rst_outs", {sif.alu_a_o, sif.alu_b_o, 13'(sif.alu_op_o), sif.batch_done_o, sif.res_err_o},
          32'h0);
      chk("rst_res_data_idx", {sif.res_data_o, 8'(sif.res_idx_o)}, 24'h0);
      reset = 1'b0;
      step();

      // single add 3+5
      clear_mon();
      pkt = '0;
      set_slot(0, 3'd1, 8'h05, 8'h03);
      done_dly        = 1;
      sif.res_ready_i = 1'b1;
      send_pkt("add");
      wait_idle("add");
      chk("add_nres", rq_data.size(), 1);
      chk("add_data", get_d(0), 16'h0008);
      chk("add_idx", get_i(0), 0);
      chk("add_err", get_e(0), 0);
      chk("add_bdone", nbdone, 1);
      chk("add_nstart", nstart, 1);
      chk("add_pkt_ready", sif.pkt_ready_o, 1);

      // mul hold in slot 3, done after 3 cycles
      clear_mon();
      pkt = '0;
      set_slot(3, 3'd4, 8'hFF, 8'hFF);
      done_dly = 3;
      send_pkt("mul");
      wait_start("mul");
      hold = 0;
      for (int i = 0; i < 3; i++) begin
         if (sif.alu_start_o && sif.alu_a_o == 8'hFF && sif.alu_b_o == 8'hFF &&
             sif.alu_op_o == 3'd4)
            hold++;
         step();
      end
      chk("mul_hold_cycles", hold, 3);
      chk("mul_start_drop", sif.alu_start_o, 0);
      wait_idle("mul");
      chk("mul_nres", rq_data.size(), 1);
      chk("mul_data", get_d(0), 16'hFE01);
      chk("mul_idx", get_i(0), 3);

      // backpressure on first of two adds; also offer a packet while busy
      clear_mon();
      pkt = '0;
      set_slot(0, 3'd1, 8'h02, 8'h01);
      set_slot(1, 3'd1, 8'h20, 8'h10);
      done_dly        = 1;
      sif.res_ready_i = 1'b0;
      send_pkt("bp");
      begin
         int n = 0;
         while (!sif.res_valid_o && n < 50) begin
            step();
            n++;
         end
      end
      chk("bp_valid_seen", sif.res_valid_o, 1);
      sif.pkt_valid_i = 1'b1;
      hold = 0;
      for (int i = 0; i < 5; i++) begin
         if (sif.res_valid_o && sif.res_data_o == 16'h0003 && sif.res_idx_o == 0 &&
             nstart == 1 && !sif.pkt_ready_o)
            hold++;
         step();
      end
      sif.pkt_valid_i = 1'b0;
      chk("bp_hold_cycles", hold, 5);
      chk("bp_no_res_yet", rq_data.size(), 0);
      sif.res_ready_i = 1'b1;
      wait_idle("bp");
      chk("bp_nres", rq_data.size(), 2);
      chk("bp_data0", {get_d(0), 8'(get_i(0))}, {16'h0003, 8'd0});
      chk("bp_data1", {get_d(1), 8'(get_i(1))}, {16'h0030, 8'd1});
      chk("bp_nstart", nstart, 2);
      chk("bp_bdone", nbdone, 1);

      // skip opcodes 0,5,6,7 then and in slot 4
      clear_mon();
      pkt = '0;
      set_slot(0, 3'd0, 8'h11, 8'h22);
      set_slot(1, 3'd5, 8'h33, 8'h44);
      set_slot(2, 3'd6, 8'h55, 8'h66);
      set_slot(3, 3'd7, 8'h77, 8'h88);
      set_slot(4, 3'd2, 8'h3C, 8'hF0);
      send_pkt("skip");
      wait_idle("skip");
      chk("skip_nstart", nstart, 1);
      chk("skip_first_a", first_a, 8'hF0);
      chk("skip_nres", rq_data.size(), 1);
      chk("skip_data", get_d(0), 16'h0030);
      chk("skip_idx", get_i(0), 4);

      // timeout on slot 0, normal completion on slot 1
      clear_mon();
      pkt = '0;
      set_slot(0, 3'd1, 8'h09, 8'h07);
      set_slot(1, 3'd1, 8'h01, 8'h01);
      done_dly = 0;
      send_pkt("to");
      wait_start("to");
      scnt = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!sif.alu_start_o) break;
         scnt++;
      end
      done_dly = 1;
      chk("to_wait_cycles", scnt, 15);
      chk("to_start_drop", sif.alu_start_o, 0);
      wait_idle("to");
      chk("to_nres", rq_data.size(), 2);
      chk("to_res0", {get_d(0), 7'(get_i(0)), get_e(0)}, {16'h0000, 7'd0, 1'b1});
      chk("to_res1", {get_d(1), 7'(get_i(1)), get_e(1)}, {16'h0002, 7'd1, 1'b0});

      // reset during WAIT of slot 10
      clear_mon();
      pkt = '0;
      set_slot(10, 3'd1, 8'h01, 8'h02);
      done_dly = 0;
      send_pkt("rst");
      wait_start("rst");
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_start", sif.alu_start_o, 0);
      chk("mid_rst_busy", sif.busy_o, 0);
      chk("mid_rst_ready", sif.pkt_ready_o, 1);
      chk("mid_rst_valid", sif.res_valid_o, 0);
      step();
      chk("mid_rst_nres", rq_data.size(), 0);
      chk("mid_rst_bdone", nbdone, 0);
      clear_mon();
      pkt = '0;
      set_slot(0, 3'd1, 8'h04, 8'h04);
      done_dly = 1;
      send_pkt("post");
      wait_idle("post");
      chk("post_nres", rq_data.size(), 1);
      chk("post_res", {get_d(0), 8'(get_i(0))}, {16'h0008, 8'd0});
      chk("post_bdone", nbdone, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
